// File: rtl/lut_key_search_if.sv
`default_nettype none
// ============================================================================
// Module      : lut_key_search_if
// Description : Request/response handshake bundle for the reverse LUT search.
// Revision    : 1.0 - initial release
// ============================================================================
interface lut_key_search_if #(
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1,
  parameter int IW       = 1
);
  logic                req_valid;
  logic                req_ready;
  logic [DATA_LEN-1:0] req_data;
  logic                resp_valid;
  logic                resp_ready;
  logic [KEY_LEN-1:0]  resp_key;
  logic                resp_hit;
  logic [IW-1:0]       resp_index;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_key, resp_hit, resp_index
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_key, resp_hit, resp_index
  );
endinterface
`default_nettype wire

// File: rtl/lut_key_search.sv
`default_nettype none
// ============================================================================
// Module      : lut_key_search
// Description : Reverse lookup (data -> key) over a packed table, one entry
//               compared per cycle, lowest matching index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_key_search #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
  input  logic [KEY_LEN-1:0]                    default_key,
  lut_key_search_if.slave                       bus
);

  localparam int W  = KEY_LEN + DATA_LEN;
  localparam int IW = (NR_KEY > 1) ? $clog2(NR_KEY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic [DATA_LEN-1:0] r_req_data, w_req_data_nxt;
  logic [KEY_LEN-1:0]  r_dkey, w_dkey_nxt;
  logic                r_resp_valid, w_resp_valid_nxt;
  logic [KEY_LEN-1:0]  r_resp_key, w_resp_key_nxt;
  logic                r_resp_hit, w_resp_hit_nxt;
  logic [IW-1:0]       r_resp_index, w_resp_index_nxt;

  logic [W-1:0]        w_entry;
  logic [KEY_LEN-1:0]  w_entry_key;
  logic [DATA_LEN-1:0] w_entry_data;
  logic                w_last;

  // Equality mux rather than a variable part-select keeps the index in range
  // for non-power-of-two table sizes.
  always_comb begin
    w_entry = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (r_idx == IW'(i)) begin
        w_entry = lut[i*W +: W];
      end
    end
  end

  assign w_entry_key  = w_entry[W-1 -: KEY_LEN];
  assign w_entry_data = w_entry[DATA_LEN-1:0];
  assign w_last       = (r_idx == IW'(NR_KEY - 1));

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_req_data_nxt   = r_req_data;
    w_dkey_nxt       = r_dkey;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_key_nxt   = r_resp_key;
    w_resp_hit_nxt   = r_resp_hit;
    w_resp_index_nxt = r_resp_index;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_req_data_nxt = bus.req_data;
          w_dkey_nxt     = default_key;
          w_idx_nxt      = '0;
          w_state_nxt    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_entry_data == r_req_data) begin
          w_resp_key_nxt   = w_entry_key;
          w_resp_hit_nxt   = 1'b1;
          w_resp_index_nxt = r_idx;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = S_RESP;
        end else if (w_last) begin
          w_resp_key_nxt   = r_dkey;
          w_resp_hit_nxt   = 1'b0;
          w_resp_index_nxt = '0;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = S_RESP;
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          w_resp_valid_nxt = 1'b0;
          w_state_nxt      = S_IDLE;
        end
      end
      default: begin
        w_resp_valid_nxt = 1'b0;
        w_state_nxt      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_req_data   <= '0;
      r_dkey       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_key   <= '0;
      r_resp_hit   <= 1'b0;
      r_resp_index <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_req_data   <= w_req_data_nxt;
      r_dkey       <= w_dkey_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_key   <= w_resp_key_nxt;
      r_resp_hit   <= w_resp_hit_nxt;
      r_resp_index <= w_resp_index_nxt;
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_key   = r_resp_key;
  assign bus.resp_hit   = r_resp_hit;
  assign bus.resp_index = r_resp_index;

endmodule
`default_nettype wire

// File: doc/lut_key_search.md
LUT_KEY_SEARCH -- requirements
Module: lut_key_search

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- NR_KEY, 2, number of table entries (>=1).
- KEY_LEN, 1, key width.
- DATA_LEN, 1, data width.
REQ-002 Derived widths SHALL be W = KEY_LEN+DATA_LEN and IW = max(1, clog2(NR_KEY)).
REQ-003 Ports SHALL be as follows: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous reset, active-low.
- lut, in, NR_KEY*W, packed table; entry i at bits [(i+1)*W-1 : i*W], key in the upper KEY_LEN bits, data in the lower DATA_LEN bits.
- default_key, in, KEY_LEN, key returned on miss.
- req_valid, in, 1, request present.
- req_ready, out, 1, block can accept a request.
- req_data, in, DATA_LEN, data value to look up.
- resp_valid, out, 1, response present.
- resp_ready, in, 1, consumer accepts the response.
- resp_key, out, KEY_LEN, matched key, or default_key on miss.
- resp_hit, out, 1, 1 = match found.
- resp_index, out, IW, index of the matched entry (0 on miss).
REQ-004 Clock and reset SHALL be one clock; reset is asynchronous and active-low.

Function
REQ-005 The block SHALL perform a reverse lookup: data to key, the inverse of the keyed mux.
REQ-006 The state machine SHALL have three states:
- IDLE: req_ready=1, resp_valid=0.
- SCAN: req_ready=0, resp_valid=0.
- RESP: req_ready=0, resp_valid=1.
REQ-007 req_ready SHALL be decoded from the state only; resp_valid SHALL be registered.
REQ-008 Accept in IDLE: on the edge where req_valid&&req_ready, the block SHALL latch req_data and default_key, clear the scan index to 0, and go to SCAN.
REQ-009 SCAN SHALL compare exactly one entry per cycle: the data field of entry idx against the latched req_data.
REQ-010 On a SCAN match, the block SHALL register resp_key=entry key, resp_hit=1, resp_index=idx, and go to RESP.
REQ-011 On a SCAN no-match with idx==NR_KEY-1, the block SHALL register resp_key=latched default_key, resp_hit=0, resp_index=0, and go to RESP.
REQ-012 On any other SCAN no-match, the block SHALL increment idx and stay in SCAN.
REQ-013 Duplicate data values SHALL resolve to the lowest index; this is defined behaviour, not an error.
REQ-014 Latency SHALL be as follows:
- Match at entry i: resp_valid high after edge A+i+1, where A is the accept edge.
- Miss: resp_valid high after edge A+NR_KEY.
REQ-015 In RESP, resp_key, resp_hit and resp_index SHALL hold stable until the edge with resp_ready=1, then the block SHALL return to IDLE.
REQ-016 resp_ready sampled while resp_valid=0 SHALL be ignored.
REQ-017 req_valid outside IDLE SHALL be ignored, and req_data SHALL not be re-latched.
REQ-018 At least one IDLE cycle SHALL separate consecutive responses, so minimum request spacing is latency+2 cycles.
REQ-019 lut SHALL be read only during SCAN, and the consumer holds lut constant from accept to response.
REQ-020 default_key changes after accept SHALL not affect the response.
REQ-021 NR_KEY=1 SHALL work: a single SCAN cycle, and resp_index is 1 bit, always 0.
REQ-022 idx SHALL never exceed NR_KEY-1, with no wrap-around, including when NR_KEY is not a power of 2.

Reset
REQ-023 While rst_n=0, the state SHALL be IDLE and all of the following SHALL be 0: resp_valid, resp_key, resp_hit, resp_index, idx, and the latched request.
REQ-024 While rst_n=0, req_ready SHALL be 1.
REQ-025 Reset asserted mid-SCAN or in RESP SHALL abort immediately, asynchronously, with no response issued.
REQ-026 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-027 The bench SHALL use NR_KEY=4, KEY_LEN=2, DATA_LEN=8, default_key=3, and this table:
- entry 0 = {3, 0x10}
- entry 1 = {1, 0x20}
- entry 2 = {0, 0x20}
- entry 3 = {2, 0x40}
REQ-028 The bench SHALL cover these directed scenarios:
- req 0x10 -> resp_hit=1, resp_key=3, resp_index=0, resp_valid after A+1.
- req 0x20 -> resp_hit=1, resp_key=1, resp_index=1 (lowest index wins over entry 2), resp_valid after A+2.
- req 0x40 -> resp_hit=1, resp_key=2, resp_index=3, resp_valid after A+4.
- req 0x55 -> resp_hit=0, resp_key=3, resp_index=0, resp_valid after A+4; changing default_key to 0 after accept leaves resp_key=3.
- resp_ready held 0 for 5 cycles in RESP, with req_valid=1 and req_data=0x40 -> outputs unchanged, req_ready=0, no new accept; resp_ready=1 -> IDLE next cycle.
- rst_n pulsed low during SCAN of req 0x40 -> resp_valid=0 with no response; req_ready=1; a new req 0x10 after release -> resp_key=3 normally.
